// File: rtl/sim_pdmem_pkg.sv
// Shared types and constants for the pipelined simulation data memory.
// The LFSR constants are only referenced when SIM_PDMEM_PIPE_STALL_INJECT_EN is defined.
package sim_pdmem_pkg;

  // Response words are carried at the widest legal data width and narrowed at the port.
  localparam int RSP_DW = 64;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic              valid;
    logic [RSP_DW-1:0] rdata;
    logic              err;
  } rsp_t;

  function automatic bit params_ok(input int depth_words, input int data_width,
                                   input int addr_width, input int latency,
                                   input int max_outstanding);
    bit ok;
    ok = 1'b1;
    if (depth_words < 1) ok = 1'b0;
    if (data_width != 32 && data_width != 64) ok = 1'b0;
    if (latency < 1 || latency > 8) ok = 1'b0;
    if (max_outstanding < 2 || max_outstanding > 16) ok = 1'b0;
    if ((max_outstanding & (max_outstanding - 1)) != 0) ok = 1'b0;
    if (addr_width < 8 || addr_width > 64) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sim_pdmem_rsp_fifo.sv
// Synchronous response FIFO of rsp_t; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module sim_pdmem_rsp_fifo
  import sim_pdmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  rsp_t i_push_data,
  input  logic i_pop,
  output rsp_t o_head,
  output logic o_empty,
  output logic o_full
);

  localparam int AW = $clog2(DEPTH);

  rsp_t          mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/sim_pdmem_pipe.sv
// Pipelined simulation data memory with valid/ready request and response channels.
// Optional stall injection: define SIM_PDMEM_PIPE_STALL_INJECT_EN.
module sim_pdmem_pipe
  import sim_pdmem_pkg::*;
#(
  parameter int DEPTH_WORDS     = 2048,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic                    i_req_we,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_req_wmask,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                    o_rsp_err
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFF  = $clog2(NB);
  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

  initial begin
    assert (params_ok(DEPTH_WORDS, DATA_WIDTH, ADDR_WIDTH, LATENCY, MAX_OUTSTANDING))
      else $fatal(1, "sim_pdmem_pipe: illegal parameter set");
  end

  logic                  accept, retire, in_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDXW-1:0]       mem_idx;
  logic [CW-1:0]         cnt_q, cnt_d;

  assign word_idx = i_req_addr >> OFF;
  assign in_range = word_idx < ADDR_WIDTH'(DEPTH_WORDS);
  assign mem_idx  = word_idx[IDXW-1:0];
  // Requests presented while reset is asserted are never accepted, so no write slips in.
  assign accept   = i_req_valid && o_req_ready && i_rst_n;
  assign retire   = o_rsp_valid && i_rsp_ready;

  // Storage array: deliberately not reset; the read register samples pre-edge contents.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rd_word_q;

  always_ff @(posedge i_clk) begin
    if (accept && !i_req_we) rd_word_q <= mem_q[mem_idx];
    if (accept && i_req_we && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (i_req_wmask[b]) mem_q[mem_idx][b*8 +: 8] <= i_req_wdata[b*8 +: 8];
      end
    end
  end

  logic s0_valid_q, s0_err_q, s0_zero_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s0_valid_q <= 1'b0;
      s0_err_q   <= 1'b0;
      s0_zero_q  <= 1'b0;
    end else begin
      s0_valid_q <= accept;
      s0_err_q   <= accept && !in_range;
      s0_zero_q  <= i_req_we || !in_range;
    end
  end

  rsp_t stage [LATENCY];

  assign stage[0] = '{valid: s0_valid_q,
                      rdata: s0_zero_q ? '0 : RSP_DW'(rd_word_q),
                      err:   s0_err_q};

  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
    rsp_t stage_q;
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) stage_q <= '0;
      else          stage_q <= stage[gi-1];
    end
    assign stage[gi] = stage_q;
  end

  rsp_t rsp_head;
  logic fifo_empty, fifo_full;

  sim_pdmem_rsp_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (stage[LATENCY-1].valid),
    .i_push_data(stage[LATENCY-1]),
    .i_pop      (retire),
    .o_head     (rsp_head),
    .o_empty    (fifo_empty),
    .o_full     (fifo_full)
  );

  assign o_rsp_valid = !fifo_empty;
  assign o_rsp_rdata = fifo_empty ? '0 : rsp_head.rdata[DATA_WIDTH-1:0];
  assign o_rsp_err   = !fifo_empty && rsp_head.err;

  // Full cannot occur: the outstanding count already bounds pipeline plus FIFO occupancy.
  logic unused_bits;
  assign unused_bits = ^{rsp_head, fifo_full};

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !retire)      cnt_d = cnt_q + CW'(1);
    else if (!accept && retire) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

`ifdef SIM_PDMEM_PIPE_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign o_req_ready = (cnt_q < CW'(MAX_OUTSTANDING)) && (lfsr_q[1:0] != 2'b00);
`else
  assign o_req_ready = (cnt_q < CW'(MAX_OUTSTANDING));
`endif

endmodule
